filter_arbiter: RTL and testbench
=================================

Name: filter_arbiter

Overview:
- Round-robin read arbiter for the bank of filter output buffers feeding the single force evaluation pipeline.
- Watches each buffer's empty flag and issues at most one one-hot read per cycle.
- Muxes the returned {r2, dx, dy, dz} entry and presents it as a registered, valid-qualified record to the force pipeline.
- Also provides a pipeline-ready throttle, an idle indication and a delivered-record counter.

Parameters:
- NUM_FILTER, 4, number of filter buffers arbitrated; power of two, 2..8.
- SEL_WIDTH, 2, log2(NUM_FILTER).
- DATA_WIDTH, 32, width of each IEEE single-precision field.
- COUNT_WIDTH, 16, width of the delivered-record counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- filter_empty  input  NUM_FILTER  per-buffer empty flag; bit i = buffer i.
- filter_rd_data  input  NUM_FILTER*4*DATA_WIDTH  buffer read data; buffer i at [i*4*DATA_WIDTH +: 4*DATA_WIDTH], packed {r2,dx,dy,dz}, dz in LSBs; valid 1 cycle after its rd_en.
- filter_rd_en  output  NUM_FILTER  one-hot (or zero) read strobe, combinational.
- force_ready  input  1  force pipeline accepts new work; gates issue only.
- count_clr  input  1  synchronous clear of out_count.
- out_valid  output  1  r2/dx/dy/dz/out_sel hold a new record this cycle.
- r2  output  DATA_WIDTH  squared distance.
- dx  output  DATA_WIDTH  x displacement.
- dy  output  DATA_WIDTH  y displacement.
- dz  output  DATA_WIDTH  z displacement.
- out_sel  output  SEL_WIDTH  index of the source buffer for the current record.
- idle  output  1  all buffers empty and no read in flight.
- out_count  output  COUNT_WIDTH  records delivered since reset/clear.

Behaviour:
- Reset (rst=0, async):
  - out_valid, r2, dx, dy, dz, out_sel, out_count, rr_ptr, pend_valid, pend_sel and last_grant are all cleared to 0.
  - filter_rd_en is 0 while rst=0.
- Eligibility, cycle T: eligible[i] = !filter_empty[i] & !last_grant[i]. last_grant is the one-hot grant registered from T-1. This mask covers the 1-cycle lag of the empty flag, so a buffer is never read on two consecutive cycles.
- Arbitration, cycle T:
  - If force_ready=1 and any eligible bit is set, grant the first eligible index searching rr_ptr, rr_ptr+1, ... modulo NUM_FILTER.
  - filter_rd_en = onehot(grant) combinationally in T.
  - Otherwise filter_rd_en=0.
- Edge ending T:
  - last_grant <= filter_rd_en.
  - If a grant was made: rr_ptr <= (grant+1) mod NUM_FILTER, pend_valid <= 1, pend_sel <= grant. Otherwise pend_valid <= 0 and rr_ptr holds.
- Capture, cycle T+1: if pend_valid, at the edge ending T+1 the block registers the slice of filter_rd_data at pend_sel into {r2,dx,dy,dz}, out_sel <= pend_sel, and out_valid <= 1. Otherwise out_valid <= 0 and the data outputs hold their last values.
- Latency: rd_en in T gives out_valid in T+2. out_valid is a single-cycle pulse per record.
- Throughput:
  - One record per cycle when 2 or more buffers are non-empty.
  - One record every 2 cycles when only one buffer is non-empty.
- force_ready=0: no new grants. A read already issued still completes and is delivered, so downstream must absorb up to 2 records after deasserting ready. force_ready never blocks the out_valid pulse.
- idle = (&filter_empty) & !pend_valid & !out_valid, combinational.
- out_count:
  - Increments by 1 on each out_valid cycle and wraps from all-ones to 0.
  - count_clr=1 forces 0, with priority over a simultaneous increment.
- Reset mid-operation: pending and captured records are discarded and not delivered after release. Arbitration restarts at index 0.
- Empty flag rising in the same cycle as a grant decision: the grant uses the flag value sampled that cycle.

Test Plan:
- Reset → filter_rd_en=0, out_valid=0, r2/dx/dy/dz=0, out_sel=0, out_count=0, rr_ptr=0.
- Only buffer 0 holds 3 entries (r2 = 0x3F800000, 0x40000000, 0x40400000), force_ready=1 → filter_rd_en=4'b0001 at cycles 0, 2, 4; out_valid at 2, 4, 6 with those r2 values in order; out_sel=0; out_count=3.
- All 4 buffers non-empty continuously → rd_en 0001, 0010, 0100, 1000, 0001 on consecutive cycles; out_sel 0, 1, 2, 3, 0 starting at cycle 2.
- rr_ptr=2, only buffers 1 and 3 non-empty → grant 3 then 1; out_sel 3, 1.
- Deassert force_ready in the cycle after a grant → no rd_en while low; the in-flight record still appears 2 cycles after its grant; issue resumes on the first cycle force_ready=1.
- Pull rst low 1 cycle after a grant → out_valid stays 0 after release, out_count=0, next grant starts from index 0. Separately, count_clr with out_valid in the same cycle → out_count=0.

Source files
------------

// File: rtl/filter_arbiter.sv
// filter_arbiter: round-robin reader of the filter output buffers feeding the force pipeline.
// Issues one-hot reads, captures the returned {r2,dx,dy,dz} entry a cycle later and counts deliveries.
module filter_arbiter #(
    parameter int NUM_FILTER  = 4,
    parameter int SEL_WIDTH   = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_FILTER-1:0]              filter_empty,
    input  logic [NUM_FILTER*4*DATA_WIDTH-1:0] filter_rd_data,
    output logic [NUM_FILTER-1:0]              filter_rd_en,
    input  logic                               force_ready,
    input  logic                               count_clr,
    output logic                               out_valid,
    output logic [DATA_WIDTH-1:0]              r2,
    output logic [DATA_WIDTH-1:0]              dx,
    output logic [DATA_WIDTH-1:0]              dy,
    output logic [DATA_WIDTH-1:0]              dz,
    output logic [SEL_WIDTH-1:0]               out_sel,
    output logic                               idle,
    output logic [COUNT_WIDTH-1:0]             out_count
);
    logic [SEL_WIDTH-1:0]  rr_ptr, pend_sel, grant, idx;
    logic [NUM_FILTER-1:0] last_grant, eligible;
    logic                  pend_valid, found, issue;

    // last_grant masks a buffer whose empty flag has not yet caught up with its previous read
    assign eligible = ~filter_empty & ~last_grant;

    // descending scan so the eligible index closest to rr_ptr wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_FILTER - 1; k >= 0; k--) begin
            idx = rr_ptr + SEL_WIDTH'(k);
            if (eligible[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign issue        = rst & force_ready & found;
    assign filter_rd_en = issue ? NUM_FILTER'(1) << grant : '0;
    assign idle         = (&filter_empty) & ~pend_valid & ~out_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr     <= '0;
            last_grant <= '0;
            pend_valid <= 1'b0;
            pend_sel   <= '0;
            out_valid  <= 1'b0;
            r2         <= '0;
            dx         <= '0;
            dy         <= '0;
            dz         <= '0;
            out_sel    <= '0;
            out_count  <= '0;
        end else begin
            last_grant <= filter_rd_en;
            pend_valid <= issue;
            if (issue) begin
                rr_ptr   <= grant + 1'b1;
                pend_sel <= grant;
            end
            out_valid <= pend_valid;
            if (pend_valid) begin
                {r2, dx, dy, dz} <= filter_rd_data[pend_sel*4*DATA_WIDTH +: 4*DATA_WIDTH];
                out_sel          <= pend_sel;
            end
            out_count <= count_clr ? '0 : out_count + COUNT_WIDTH'(out_valid);
        end
    end
endmodule

// File: tb/tb_filter_arbiter.sv
// tb_filter_arbiter: buffer model, reference arbiter and record scoreboard for filter_arbiter.
module tb_filter_arbiter;
    localparam int N = 4, SW = 2, DW = 32, CW = 16, EW = 4 * DW, DEPTH = 512;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    filter_empty, filter_rd_en;
    logic [N*EW-1:0] filter_rd_data = '0;
    logic            force_ready = 1'b0, count_clr = 1'b0;
    logic            out_valid, idle;
    logic [DW-1:0]   r2, dx, dy, dz;
    logic [SW-1:0]   out_sel;
    logic [CW-1:0]   out_count;

    int total = 0, bad = 0, cyc = 0;

    logic [EW-1:0] mem [N][DEPTH];
    int wr [N] = '{default: 0};
    int rd [N] = '{default: 0};

    typedef struct {
        logic [EW-1:0] d;
        logic [SW-1:0] s;
        int            due;
    } rec_t;
    rec_t sb[$];

    logic [SW-1:0] m_ptr = '0;
    logic [N-1:0]  m_last = '0;
    logic          m_pend = 1'b0, m_ov = 1'b0;
    logic [CW-1:0] m_cnt = '0;

    filter_arbiter #(.NUM_FILTER(N), .SEL_WIDTH(SW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .filter_empty(filter_empty), .filter_rd_data(filter_rd_data),
        .filter_rd_en(filter_rd_en), .force_ready(force_ready), .count_clr(count_clr),
        .out_valid(out_valid), .r2(r2), .dx(dx), .dy(dy), .dz(dz), .out_sel(out_sel),
        .idle(idle), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    always_comb
        for (int i = 0; i < N; i++) filter_empty[i] = (rd[i] == wr[i]);

    // buffer returns the head entry the cycle after its read strobe
    always @(posedge clk)
        for (int i = 0; i < N; i++)
            if (filter_rd_en[i] && rd[i] != wr[i]) begin
                filter_rd_data[i*EW +: EW] <= mem[i][rd[i]];
                rd[i] <= rd[i] + 1;
            end

    always @(negedge clk) begin
        logic [N-1:0]  el, ee;
        logic [SW-1:0] g, ix;
        logic          f;
        rec_t          r;
        cyc++;
        if (!rst) begin
            check("rst_rden", filter_rd_en, 0);
            check("rst_valid", out_valid, 0);
            check("rst_count", out_count, 0);
            m_ptr = '0; m_last = '0; m_pend = 0; m_ov = 0; m_cnt = '0;
            sb.delete();
        end else begin
            el = ~filter_empty & ~m_last;
            f = 0;
            g = '0;
            for (int k = 0; k < N; k++) begin
                ix = m_ptr + SW'(k);
                if (!f && el[ix]) begin
                    g = ix;
                    f = 1;
                end
            end
            ee = (force_ready && f) ? N'(1) << g : '0;
            check("rd_en", filter_rd_en, ee);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                r = sb.pop_front();
                check("valid", out_valid, 1);
                check("data", {r2, dx, dy, dz}, r.d);
                check("sel", out_sel, r.s);
            end else check("valid", out_valid, 0);
            check("count", out_count, m_cnt);
            check("idle", idle, (&filter_empty) && !m_pend && !m_ov);
            m_cnt  = count_clr ? '0 : m_cnt + CW'(m_ov);
            m_ov   = m_pend;
            m_pend = |ee;
            m_last = ee;
            if (|ee) begin
                m_ptr = g + 1'b1;
                r = '{mem[g][rd[g]], g, cyc + 2};
                sb.push_back(r);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [DW-1:0] rv);
        mem[i][wr[i]] = {rv, DW'(i), DW'(wr[i]), ~rv};
        wr[i]++;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_r2", r2, 0);
        check("rst_dx", dx, 0);
        check("rst_dy", dy, 0);
        check("rst_dz", dz, 0);
        check("rst_sel", out_sel, 0);
        step(1);
        rst = 1'b1;
        force_ready = 1'b1;
        step(2);
        // single buffer: one read every other cycle
        load(0, 32'h3F800000);
        load(0, 32'h40000000);
        load(0, 32'h40400000);
        step(10);
        check("single_count", out_count, 3);
        // restart pointer at 0, then all four buffers busy
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        for (int e = 0; e < 5; e++)
            for (int i = 0; i < N; i++) load(i, 32'h41000000 + DW'(e * N + i));
        step(26);
        // steer rr_ptr to 2, then only buffers 1 and 3 ready
        load(1, 32'h42000000);
        step(4);
        load(1, 32'h42000001);
        load(3, 32'h42000003);
        @(negedge clk);
        check("rr_first", filter_rd_en, 4'b1000);
        @(negedge clk);
        check("rr_second", filter_rd_en, 4'b0010);
        step(5);
        // throttle right after a grant
        for (int i = 0; i < N; i++) begin
            load(i, 32'h43000000 + DW'(i));
            load(i, 32'h43100000 + DW'(i));
        end
        step(1);
        force_ready = 1'b0;
        @(negedge clk);
        check("thr_none", filter_rd_en, 0);
        step(4);
        force_ready = 1'b1;
        step(12);
        // reset with a read in flight
        load(2, 32'h44000002);
        step(1);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        check("rst_mid_count", out_count, 0);
        load(1, 32'h44000001);
        load(3, 32'h44000003);
        @(negedge clk);
        check("rst_mid_grant", filter_rd_en, 4'b0010);
        step(6);
        // clear collides with a delivery
        load(0, 32'h45000000);
        step(2);
        count_clr = 1'b1;
        step(1);
        count_clr = 1'b0;
        @(negedge clk);
        check("clr_count", out_count, 0);
        step(3);
        // random traffic and throttling
        for (int c = 0; c < 150; c++) begin
            if ($urandom_range(0, 2) != 0) load($urandom_range(0, N - 1), $urandom);
            force_ready = ($urandom_range(0, 3) != 0);
            count_clr   = ($urandom_range(0, 19) == 0);
            step(1);
        end
        force_ready = 1'b1;
        count_clr   = 1'b0;
        step(600);
        check("sb_drained", sb.size(), 0);
        check("end_idle", idle, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
